regfile_write_port: RTL and testbench

Write-side initiator for the register file: merges single-cycle pipeline writeback results with results from the long-latency multiply/divide unit (MDU) into one register-file write per cycle. Pipeline writebacks always win the port. MDU results wait in a small FIFO until the port is free. The block also provides a forwarding lookup so decode can see MDU results that are queued but not yet committed.

---
 rtl/regfile_write_port.sv | 143 ++++++++++++++
 tb/tb_regfile_write_port.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_port.sv
// Merges pipeline writebacks and queued MDU results onto one register-file write port.
// Latency: pipeline write appears on A3/WD3/WE3 at the sampling edge; an MDU result pops one edge after enqueue when the port is idle.
// Backpressure: pipeline writes always win and cannot stall; MDU is held off via mdu_ready (= !full).
module regfile_write_port #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       mdu_valid,
  output logic                       mdu_ready,
  input  logic [ADDR_W-1:0]          mdu_addr,
  input  logic [DATA_W-1:0]          mdu_data,
  output logic [ADDR_W-1:0]          A3,
  output logic [DATA_W-1:0]          WD3,
  output logic                       WE3,
  input  logic [ADDR_W-1:0]          fwd_addr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [ADDR_W-1:0] ent_addr_d [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DATA_W-1:0] ent_data_d [DEPTH];
  logic [DEPTH-1:0]  kill_q, kill_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              we3_q, we3_d;

  logic [PW-1:0]     count;
  logic [IW-1:0]     wr_idx, rd_idx;
  logic              full, empty, wb_eff, push;

  // Occupancy and handshake qualifiers; extra pointer bit separates full from empty
  always_comb begin
    count     = wr_ptr_q - rd_ptr_q;
    wr_idx    = wr_ptr_q[IW-1:0];
    rd_idx    = rd_ptr_q[IW-1:0];
    full      = (count == PW'(DEPTH));
    empty     = (count == '0);
    mdu_ready = !full;
    wb_eff    = wb_valid && (wb_addr != '0);
    // r0 offers complete the handshake but are dropped
    push      = mdu_valid && !full && (mdu_addr != '0);
    q_count   = count;
  end

  // Next state: kill matching entries, enqueue, then arbitrate the write port
  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    kill_d     = kill_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    a3_d       = a3_q;
    wd3_d      = wd3_q;
    we3_d      = 1'b0;

    if (wb_eff) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_addr_q[i] == wb_addr) kill_d[i] = 1'b1;
      end
    end

    if (push) begin
      ent_addr_d[wr_idx] = mdu_addr;
      ent_data_d[wr_idx] = mdu_data;
      // a same-edge pipeline write to the same register is the newer value
      kill_d[wr_idx]     = wb_eff && (wb_addr == mdu_addr);
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end

    if (wb_eff) begin
      we3_d = 1'b1;
      a3_d  = wb_addr;
      wd3_d = wb_data;
    end else if (!empty) begin
      // a killed head still uses up this cycle's pop slot
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (!kill_q[rd_idx]) begin
        we3_d = 1'b1;
        a3_d  = ent_addr_q[rd_idx];
        wd3_d = ent_data_q[rd_idx];
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
      kill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      a3_q     <= '0;
      wd3_q    <= '0;
      we3_q    <= 1'b0;
    end else begin
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
      kill_q     <= kill_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
      we3_q      <= we3_d;
    end
  end

  // Forwarding scan oldest to newest over live entries so the newest match wins
  always_comb begin
    logic [IW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_idx + IW'(k);
      if ((PW'(k) < count) && !kill_q[idx] && (fwd_addr != '0) &&
          (ent_addr_q[idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data_q[idx];
      end
    end
  end

  assign A3  = a3_q;
  assign WD3 = wd3_q;
  assign WE3 = we3_q;

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port: reset, priority, backpressure, kill, r0, wrap and forwarding.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each scenario task checks its own expectations inline.
module tb_regfile_write_port;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  q_count;

  int checks = 0;
  int passes = 0;

  regfile_write_port #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .A3(A3), .WD3(WD3), .WE3(WE3),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .q_count(q_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; idle_inputs(); fwd_addr = 5'd0;
    #3;
    checks++;
    if ({WE3, A3, WD3, q_count, mdu_ready, fwd_hit, fwd_data} !==
        {1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 32'd0})
      $display("FAIL reset_state: got we=%b a=%0d wd=%h cnt=%0d rdy=%b hit=%b fd=%h",
               WE3, A3, WD3, q_count, mdu_ready, fwd_hit, fwd_data);
    else passes++;
    tick(); tick();
    RESET = 1'b0;
    tick();
    // fill three entries behind a stalling pipeline writer
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
    for (int i = 0; i < 3; i++) begin
      mdu_valid = 1'b1; mdu_addr = 5'(2 + i); mdu_data = 32'(i);
      tick();
    end
    checks++;
    if ({q_count, WE3} !== {3'd3, 1'b1})
      $display("FAIL reset_fill: cnt=%0d we=%b, want cnt=3 we=1", q_count, WE3);
    else passes++;
    #2; idle_inputs(); RESET = 1'b1;
    #1;
    checks++;
    if ({WE3, q_count, mdu_ready} !== {1'b0, 3'd0, 1'b1})
      $display("FAIL reset_mid: we=%b cnt=%0d rdy=%b, want 0 0 1", WE3, q_count, mdu_ready);
    else passes++;
    #1; RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (WE3 !== 1'b0) $display("FAIL reset_no_write: cycle %0d we=%b, want 0", i, WE3);
      else passes++;
    end
  endtask

  task automatic test_priority();
    fwd_addr = 5'd9;
    wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'h11111111;
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'hAAAA0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      mdu_valid = 1'b0;
      checks++;
      if ({WE3, A3, WD3, fwd_hit, fwd_data, q_count} !==
          {1'b1, 5'd8, 32'h11111111, 1'b1, 32'hAAAA0001, 3'd1})
        $display("FAIL prio_c%0d: we=%b a=%0d wd=%h hit=%b fd=%h cnt=%0d, want 1 8 11111111 1 aaaa0001 1",
                 c, WE3, A3, WD3, fwd_hit, fwd_data, q_count);
      else passes++;
    end
    wb_valid = 1'b0;
    tick();
    checks++;
    if ({WE3, A3, WD3, fwd_hit, q_count} !== {1'b1, 5'd9, 32'hAAAA0001, 1'b0, 3'd0})
      $display("FAIL prio_mdu: we=%b a=%0d wd=%h hit=%b cnt=%0d, want 1 9 aaaa0001 0 0",
               WE3, A3, WD3, fwd_hit, q_count);
    else passes++;
    fwd_addr = 5'd0;
  endtask

  task automatic test_full();
    int nxt = 2;
    int exp_a = 2;
    logic hs;
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
    for (int c = 0; c < 5; c++) begin
      mdu_valid = 1'b1; mdu_addr = 5'(nxt); mdu_data = 32'h100 + 32'(nxt);
      hs = mdu_ready;
      tick();
      if (hs) nxt++;
    end
    checks++;
    if ({mdu_ready, q_count, nxt} !== {1'b0, 3'd4, 6})
      $display("FAIL full_bp: rdy=%b cnt=%0d accepted_to=r%0d, want 0 4 r6", mdu_ready, q_count, nxt);
    else passes++;
    wb_valid = 1'b0;
    for (int c = 0; c < 12 && exp_a <= 7; c++) begin
      if (nxt <= 7) begin
        mdu_valid = 1'b1; mdu_addr = 5'(nxt); mdu_data = 32'h100 + 32'(nxt);
      end else mdu_valid = 1'b0;
      hs = mdu_valid && mdu_ready;
      tick();
      if (hs) nxt++;
      if (WE3 === 1'b1) begin
        checks++;
        if ({A3, WD3} !== {5'(exp_a), 32'h100 + 32'(exp_a)})
          $display("FAIL full_order: a=%0d wd=%h, want %0d %h", A3, WD3, exp_a, 32'h100 + 32'(exp_a));
        else passes++;
        exp_a++;
      end
    end
    mdu_valid = 1'b0;
    checks++;
    if ({exp_a, q_count} !== {8, 3'd0})
      $display("FAIL full_drain: next_expected=r%0d cnt=%0d, want r8 0", exp_a, q_count);
    else passes++;
  endtask

  task automatic test_kill_queued();
    fwd_addr = 5'd5;
    mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'hDEAD;
    tick();
    mdu_valid = 1'b0;
    checks++;
    if ({WE3, fwd_hit, fwd_data, q_count} !== {1'b0, 1'b1, 32'hDEAD, 3'd1})
      $display("FAIL kq_enq: we=%b hit=%b fd=%h cnt=%0d, want 0 1 dead 1", WE3, fwd_hit, fwd_data, q_count);
    else passes++;
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hBEEF;
    tick();
    wb_valid = 1'b0;
    checks++;
    if ({WE3, A3, WD3, fwd_hit, fwd_data, q_count} !== {1'b1, 5'd5, 32'hBEEF, 1'b0, 32'd0, 3'd1})
      $display("FAIL kq_kill: we=%b a=%0d wd=%h hit=%b fd=%h cnt=%0d, want 1 5 beef 0 0 1",
               WE3, A3, WD3, fwd_hit, fwd_data, q_count);
    else passes++;
    tick();
    checks++;
    if ({WE3, A3, WD3, q_count} !== {1'b0, 5'd5, 32'hBEEF, 3'd0})
      $display("FAIL kq_pop: we=%b a=%0d wd=%h cnt=%0d, want 0 5 beef 0", WE3, A3, WD3, q_count);
    else passes++;
    fwd_addr = 5'd0;
  endtask

  task automatic test_kill_same_and_r0();
    mdu_valid = 1'b1; mdu_addr = 5'd12; mdu_data = 32'h1;
    wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'h2;
    tick();
    idle_inputs();
    checks++;
    if ({WE3, A3, WD3, q_count} !== {1'b1, 5'd12, 32'h2, 3'd1})
      $display("FAIL ks_same: we=%b a=%0d wd=%h cnt=%0d, want 1 12 2 1", WE3, A3, WD3, q_count);
    else passes++;
    tick();
    checks++;
    if ({WE3, A3, WD3, q_count} !== {1'b0, 5'd12, 32'h2, 3'd0})
      $display("FAIL ks_pop: we=%b a=%0d wd=%h cnt=%0d, want 0 12 2 0", WE3, A3, WD3, q_count);
    else passes++;
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h55;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h66;
    tick();
    idle_inputs();
    checks++;
    if ({WE3, A3, WD3, q_count, mdu_ready} !== {1'b0, 5'd12, 32'h2, 3'd0, 1'b1})
      $display("FAIL r0: we=%b a=%0d wd=%h cnt=%0d rdy=%b, want 0 12 2 0 1", WE3, A3, WD3, q_count, mdu_ready);
    else passes++;
  endtask

  task automatic test_wrap_and_fwd();
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        mdu_valid = 1'b1; mdu_addr = 5'(16 + i); mdu_data = 32'h200 + 32'(i);
      end else mdu_valid = 1'b0;
      tick();
      if (i > 0) begin
        checks++;
        if ({WE3, A3, WD3} !== {1'b1, 5'(16 + i - 1), 32'h200 + 32'(i - 1)})
          $display("FAIL wrap_%0d: we=%b a=%0d wd=%h, want 1 %0d %h", i - 1, WE3, A3, WD3,
                   16 + i - 1, 32'h200 + 32'(i - 1));
        else passes++;
      end
    end
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h7;
    fwd_addr = 5'd3;
    mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'h10;
    tick();
    checks++;
    if ({fwd_hit, fwd_data} !== {1'b1, 32'h10})
      $display("FAIL fwd_one: hit=%b fd=%h, want 1 10", fwd_hit, fwd_data);
    else passes++;
    mdu_data = 32'h20;
    tick();
    mdu_valid = 1'b0;
    checks++;
    if ({fwd_hit, fwd_data, q_count} !== {1'b1, 32'h20, 3'd2})
      $display("FAIL fwd_newest: hit=%b fd=%h cnt=%0d, want 1 20 2", fwd_hit, fwd_data, q_count);
    else passes++;
    fwd_addr = 5'd0;
    #1;
    checks++;
    if ({fwd_hit, fwd_data} !== {1'b0, 32'd0})
      $display("FAIL fwd_r0: hit=%b fd=%h, want 0 0", fwd_hit, fwd_data);
    else passes++;
    wb_valid = 1'b0;
    tick();
    checks++;
    if ({WE3, A3, WD3} !== {1'b1, 5'd3, 32'h10})
      $display("FAIL fwd_drain1: we=%b a=%0d wd=%h, want 1 3 10", WE3, A3, WD3);
    else passes++;
    tick();
    checks++;
    if ({WE3, A3, WD3, q_count} !== {1'b1, 5'd3, 32'h20, 3'd0})
      $display("FAIL fwd_drain2: we=%b a=%0d wd=%h cnt=%0d, want 1 3 20 0", WE3, A3, WD3, q_count);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_full();
    test_kill_queued();
    test_kill_same_and_r0();
    test_wrap_and_fwd();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
